hps_bridge_stream_mailbox: RTL and testbench

//  Parametrised slave on the HPS external-bus bridge (addr/bus_enable/r_wbar/byte_enable/ack/irq). It

---
 rtl/hps_bridge_if.sv | 25 ++
 rtl/hps_bridge_stream_mailbox.sv | 167 ++++++++++++++++
 tb/tb_hps_bridge_stream_mailbox.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_bridge_if.sv
// rtl/hps_bridge_if.sv - HPS external-bus bridge signal bundle
interface hps_bridge_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int BUS_WIDTH  = 32,
  parameter int BUS_BYTES  = 4
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  bus_enable;
  logic                  r_wbar;
  logic [BUS_BYTES-1:0]  byte_enable;
  logic [BUS_WIDTH-1:0]  write_data;
  logic [BUS_WIDTH-1:0]  read_data;
  logic                  ack;
  logic                  irq;

  modport master (
    output addr, bus_enable, r_wbar, byte_enable, write_data,
    input  read_data, ack, irq
  );

  modport slave (
    input  addr, bus_enable, r_wbar, byte_enable, write_data,
    output read_data, ack, irq
  );
endinterface

// File: rtl/hps_bridge_stream_mailbox.sv
// rtl/hps_bridge_stream_mailbox.sv - bridge slave with TX pixel FIFO, RX result FIFO, status and masked IRQs
module hps_bridge_stream_mailbox #(
  parameter int ADDR_WIDTH = 5,
  parameter int BUS_WIDTH  = 32,
  parameter int BUS_BYTES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hps_bridge_if.slave           bus,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  input  logic [RES_WIDTH-1:0]  res_data,
  input  logic                  res_valid,
  output logic                  res_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] W_CTRL     = WW'(0);
  localparam logic [WW-1:0] W_STATUS   = WW'(1);
  localparam logic [WW-1:0] W_IRQ_EN   = WW'(2);
  localparam logic [WW-1:0] W_IRQ_STAT = WW'(3);
  localparam logic [WW-1:0] W_TX_DATA  = WW'(4);
  localparam logic [WW-1:0] W_RX_DATA  = WW'(5);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_TX_WAIT, S_ACK} state_t;
  state_t state, state_next;

  logic                  ctrl_en;
  logic [3:0]            irq_en, irq_stat, irq_en_next, irq_stat_next, w1c, irq_set;
  logic                  irq_q;
  logic [BUS_WIDTH-1:0]  rdata_q, rd_val;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [RES_WIDTH-1:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]         tx_count, rx_count, tx_count_next, rx_count_next;

  logic [WW-1:0] word;
  logic req, wr, rd;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic flush, tx_push_req, tx_push_ok, tx_push, tx_pop, rx_push, rx_pop, rx_rd, underflow;
  logic unused_ok;

  assign word     = bus.addr[ADDR_WIDTH-1:2];
  assign req      = (state == S_IDLE) && bus.bus_enable;
  assign wr       = req && !bus.r_wbar;
  assign rd       = req && bus.r_wbar;
  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  assign pix_valid = !tx_empty && ctrl_en;
  assign pix_data  = tx_mem[tx_rp];
  assign res_ready = !rx_full && ctrl_en;

  // Flush dominates everything that would move a FIFO pointer this cycle.
  assign flush       = wr && (word == W_CTRL) && bus.byte_enable[0] && bus.write_data[1];
  assign tx_push_req = (wr && (word == W_TX_DATA)) || (state == S_TX_WAIT);
  assign tx_push_ok  = tx_push_req && (!tx_full || (pix_valid && pix_ready));
  assign tx_push     = tx_push_ok && !flush;
  assign tx_pop      = pix_valid && pix_ready && !flush;
  assign rx_push     = res_valid && res_ready && !flush;
  assign rx_rd       = rd && (word == W_RX_DATA);
  assign rx_pop      = rx_rd && !rx_empty && !flush;
  assign underflow   = rx_rd && rx_empty;

  assign tx_count_next = flush ? '0 : tx_count + CW'(tx_push) - CW'(tx_pop);
  assign rx_count_next = flush ? '0 : rx_count + CW'(rx_push) - CW'(rx_pop);

  always_comb begin
    irq_set[0] = (rx_count == '0) && (rx_count_next != '0);
    irq_set[1] = (tx_count != '0) && (tx_count_next == '0);
    irq_set[2] = underflow;
    irq_set[3] = !rx_full && (rx_count_next == FULL_CNT);
    w1c = (wr && (word == W_IRQ_STAT) && bus.byte_enable[0]) ? bus.write_data[3:0] : 4'b0;
    irq_stat_next = (irq_stat & ~w1c) | irq_set;
    irq_en_next = (wr && (word == W_IRQ_EN) && bus.byte_enable[0]) ? bus.write_data[3:0] : irq_en;
  end

  always_comb begin
    rd_val = '0;
    case (word)
      W_CTRL:     rd_val[0] = ctrl_en;
      W_STATUS: begin
        rd_val[CW-1:0]  = tx_count;
        rd_val[8 +: CW] = rx_count;
        rd_val[16]      = tx_full;
        rd_val[17]      = tx_empty;
        rd_val[18]      = rx_full;
        rd_val[19]      = rx_empty;
      end
      W_IRQ_EN:   rd_val[3:0] = irq_en;
      W_IRQ_STAT: rd_val[3:0] = irq_stat;
      W_RX_DATA:  if (!rx_empty) rd_val[RES_WIDTH-1:0] = rx_mem[rx_rp];
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:
        if (bus.bus_enable) begin
          if (wr && (word == W_TX_DATA) && !tx_push_ok) state_next = S_TX_WAIT;
          else                                          state_next = S_ACK;
        end
      S_TX_WAIT: if (tx_push) state_next = S_ACK;
      S_ACK:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ctrl_en  <= 1'b0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      state    <= state_next;
      irq_en   <= irq_en_next;
      irq_stat <= irq_stat_next;
      irq_q    <= |(irq_stat_next & irq_en_next);
      tx_count <= tx_count_next;
      rx_count <= rx_count_next;
      if (req) rdata_q <= rd ? rd_val : '0;
      if (wr && (word == W_CTRL) && bus.byte_enable[0]) ctrl_en <= bus.write_data[0];
      if (flush) begin
        tx_wp <= '0;
        tx_rp <= '0;
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.write_data[DATA_WIDTH-1:0];
    if (rx_push) rx_mem[rx_wp] <= res_data;
  end

  assign bus.ack       = (state == S_ACK);
  assign bus.read_data = (state == S_ACK) ? rdata_q : '0;
  assign bus.irq       = irq_q;

  assign unused_ok = ^{bus.addr[1:0], bus.write_data, bus.byte_enable};
endmodule

// File: tb/tb_hps_bridge_stream_mailbox.sv
// tb/tb_hps_bridge_stream_mailbox.sv - directed self-checking bench for hps_bridge_stream_mailbox
module tb_hps_bridge_stream_mailbox;
  logic clk = 1'b0;
  logic rst;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_ready;
  logic [31:0] res_data;
  logic        res_valid, res_ready;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hps_bridge_if #(.ADDR_WIDTH(5), .BUS_WIDTH(32), .BUS_BYTES(4)) bus ();

  hps_bridge_stream_mailbox #(
    .ADDR_WIDTH(5), .BUS_WIDTH(32), .BUS_BYTES(4),
    .DATA_WIDTH(8), .RES_WIDTH(32), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  task automatic bus_access(input logic [4:0] a, input logic rw, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rdv, output int lat);
    @(negedge clk);
    bus.addr = a; bus.r_wbar = rw; bus.byte_enable = be; bus.write_data = wd;
    bus.bus_enable = 1'b1;
    lat = 0; rdv = '0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
    end while (bus.ack !== 1'b1 && lat < 50);
    if (bus.ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%h: ack=%b after %0d cycles, required 1", a, bus.ack, lat);
    end else rdv = bus.read_data;
    bus.bus_enable = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] d; int l;
    bus_access(a, 1'b0, be, wd, d, l);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    int l;
    bus_access(a, 1'b1, 4'hF, 32'h0, d, l);
  endtask

  task automatic push_res(input logic [31:0] w);
    res_data = w; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    bus.bus_enable = 1'b0; bus.addr = '0; bus.r_wbar = 1'b0; bus.byte_enable = '0; bus.write_data = '0;
    pix_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ack, bus.irq, pix_valid, res_ready} !== 4'b0 || bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack/irq/pix_valid/res_ready=%b rd=%h, required 0000 0", {bus.ack, bus.irq, pix_valid, res_ready}, bus.read_data);
    end
    rst = 1'b0;
    bus_read(5'h04, d);
    checks++; if (d !== 32'h000A0000) begin errors++; $display("FAIL reset_status: got %h, required 000a0000", d); end
    bus_read(5'h00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, required 0", d); end
  endtask

  task automatic test_tx_basic;
    logic [31:0] d; int l;
    pix_ready = 1'b1;
    bus_write(5'h00, 32'h1, 4'h1);
    bus_access(5'h10, 1'b0, 4'hF, 32'hFFFF_FFA5, d, l);
    checks++; if (l !== 1) begin errors++; $display("FAIL tx_ack_latency: got %0d, required 1", l); end
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hA5) begin
      errors++; $display("FAIL tx_head: pix_valid=%b pix_data=%h, required 1 a5", pix_valid, pix_data);
    end
    bus_access(5'h04, 1'b1, 4'hF, 32'h0, d, l);
    checks++; if (d !== 32'h000A0000) begin errors++; $display("FAIL tx_drained_status: got %h, required 000a0000", d); end
    checks++; if (l !== 1) begin errors++; $display("FAIL read_ack_latency: got %0d, required 1", l); end
    bus_write(5'h18, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'h18, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h, required 0", d); end
  endtask

  task automatic test_tx_full_wait;
    logic [31:0] d; int l; int bad; int n; logic [7:0] last; logic [7:0] exp_v;
    pix_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus_access(5'h10, 1'b0, 4'hF, 32'h40 + i, d, l);
      if (l != 1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_latency: %0d slow acks, required 0", bad); end
    bus_read(5'h04, d);
    checks++; if (d !== 32'h00090010) begin errors++; $display("FAIL tx_full_status: got %h, required 00090010", d); end
    @(negedge clk);
    bus.addr = 5'h10; bus.r_wbar = 1'b0; bus.byte_enable = 4'hF; bus.write_data = 32'h99; bus.bus_enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tx_wait_no_ack: %0d acks, required 0", bad); end
    pix_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    pix_ready = 1'b0;
    checks++;
    if (bus.ack !== 1'b1 || pix_data !== 8'h41) begin
      errors++; $display("FAIL tx_wait_release: ack=%b head=%h, required 1 41", bus.ack, pix_data);
    end
    bus.bus_enable = 1'b0;
    pix_ready = 1'b1;
    n = 0; bad = 0; last = 8'h0;
    for (int i = 0; i < 40; i++) begin
      if (pix_valid === 1'b1) begin
        exp_v = (n < 15) ? 8'(8'h41 + n) : 8'h99;
        if (pix_data !== exp_v) bad++;
        last = pix_data; n++;
      end
      @(posedge clk); @(negedge clk);
    end
    pix_ready = 1'b0;
    checks++;
    if (n != 16 || bad != 0 || last !== 8'h99) begin
      errors++; $display("FAIL tx_drain: count=%0d bad=%0d last=%h, required 16 0 99", n, bad, last);
    end
  endtask

  task automatic test_rx_irq;
    logic [31:0] d;
    bus_write(5'h0C, 32'hF, 4'h1);
    bus_write(5'h08, 32'h1, 4'h1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b, required 0", bus.irq); end
    push_res(32'h11);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b, required 1", bus.irq); end
    push_res(32'h22);
    push_res(32'h33);
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL irq_stat_rx: got %h, required 1", d); end
    bus_read(5'h14, d);
    checks++; if (d !== 32'h11) begin errors++; $display("FAIL rx_pop0: got %h, required 11", d); end
    bus_read(5'h14, d);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL rx_pop1: got %h, required 22", d); end
    bus_read(5'h14, d);
    checks++; if (d !== 32'h33) begin errors++; $display("FAIL rx_pop2: got %h, required 33", d); end
    bus_read(5'h14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_underflow_data: got %h, required 0", d); end
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL irq_stat_underflow: got %h, required 5", d); end
  endtask

  task automatic test_w1c;
    logic [31:0] d;
    bus_write(5'h0C, 32'hF, 4'h0);
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL w1c_no_be: got %h, required 5", d); end
    bus_write(5'h0C, 32'h5, 4'h1);
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h, required 0", d); end
    @(negedge clk);
    bus.addr = 5'h0C; bus.r_wbar = 1'b0; bus.byte_enable = 4'h1; bus.write_data = 32'h1; bus.bus_enable = 1'b1;
    res_data = 32'h44; res_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    res_valid = 1'b0;
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL w1c_collision_ack: got %b, required 1", bus.ack); end
    bus.bus_enable = 1'b0;
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL set_beats_clear: got %h, required 1", d); end
    bus_read(5'h14, d);
    checks++; if (d !== 32'h44) begin errors++; $display("FAIL rx_after_collision: got %h, required 44", d); end
  endtask

  task automatic test_flush;
    logic [31:0] d;
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(5'h10, 32'h10 + i, 4'hF);
    for (int i = 0; i < 4; i++) push_res(32'h50 + i);
    bus_read(5'h04, d);
    checks++; if (d !== 32'h00000405) begin errors++; $display("FAIL pre_flush_status: got %h, required 00000405", d); end
    @(negedge clk);
    bus.addr = 5'h00; bus.r_wbar = 1'b0; bus.byte_enable = 4'h1; bus.write_data = 32'h3; bus.bus_enable = 1'b1;
    res_data = 32'h77; res_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (bus.ack !== 1'b1 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: ack=%b pix_valid=%b, required 1 0", bus.ack, pix_valid);
    end
    bus.bus_enable = 1'b0;
    bus_read(5'h04, d);
    checks++; if (d !== 32'h000A0000) begin errors++; $display("FAIL post_flush_status: got %h, required 000a0000", d); end
    bus_read(5'h00, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_self_clear: got %h, required 1", d); end
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL flush_irq_stat: got %h, required 3", d); end
  endtask

  task automatic test_reset_in_tx_wait;
    logic [31:0] d; int bad;
    bus_write(5'h08, 32'hF, 4'h1);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_before_rst: got %b, required 1", bus.irq); end
    for (int i = 0; i < 16; i++) bus_write(5'h10, 32'h60 + i, 4'hF);
    @(negedge clk);
    bus.addr = 5'h10; bus.r_wbar = 1'b0; bus.byte_enable = 4'hF; bus.write_data = 32'hEE; bus.bus_enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.ack, bus.irq, pix_valid, res_ready} !== 4'b0 || bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_wait_outputs: ack/irq/pix_valid/res_ready=%b rd=%h, required 0000 0", {bus.ack, bus.irq, pix_valid, res_ready}, bus.read_data);
    end
    rst = 1'b0;
    bus.bus_enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_ack: %0d acks, required 0", bad); end
    bus_read(5'h04, d);
    checks++; if (d !== 32'h000A0000) begin errors++; $display("FAIL rst_status: got %h, required 000a0000", d); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full_wait();
    test_rx_irq();
    test_w1c();
    test_flush();
    test_reset_in_tx_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
